// File: rtl/dispatcher_iwrr.sv
// dispatcher_iwrr: one source stream dispatched to P_CONSUMER_NUM consumers in
// interleaved weighted round-robin order, through a single output buffer.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   src_valid_i  - source item valid
//   src_data_i   - source payload
//   src_ready_o  - source item accepted when src_valid_i & src_ready_o
//   cons_en_i    - per-consumer enable mask; disabled consumers are skipped
//   dst_valid_o  - one-hot (or zero) valid toward the consumers
//   dst_data_o   - buffered payload, broadcast to all consumers
//   dst_ready_i  - per-consumer ready
module dispatcher_iwrr #(
  parameter int unsigned                    P_CONSUMER_NUM    = 3,
  parameter logic [0:P_CONSUMER_NUM*32-1]   P_CONSUMER_WEIGHT = {32'd5, 32'd3, 32'd2},
  parameter int unsigned                    P_DATA_W          = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      src_valid_i,
  input  logic [P_DATA_W-1:0]       src_data_i,
  output logic                      src_ready_o,
  input  logic [P_CONSUMER_NUM-1:0] cons_en_i,
  output logic [P_CONSUMER_NUM-1:0] dst_valid_o,
  output logic [P_DATA_W-1:0]       dst_data_o,
  input  logic [P_CONSUMER_NUM-1:0] dst_ready_i
);

  localparam int unsigned W0 = P_CONSUMER_WEIGHT[0:31];
  localparam int unsigned RW = (W0 > 1) ? $clog2(W0) : 1;
  localparam int unsigned PW = (P_CONSUMER_NUM > 1) ? $clog2(P_CONSUMER_NUM) : 1;

  function automatic int unsigned weight(input int unsigned idx);
    return P_CONSUMER_WEIGHT[idx*32 +: 32];
  endfunction

  logic [RW-1:0]             round_q;
  logic [PW-1:0]             ptr_q;
  logic [P_CONSUMER_NUM-1:0] tgt_q;   // one-hot target; zero means buffer empty
  logic [P_DATA_W-1:0]       data_q;

  logic                      hit_a, hit_b, hit_c;
  logic [PW-1:0]             idx_a, idx_b, idx_c;
  logic                      last_round;
  logic [RW-1:0]             sel_round;
  logic [PW-1:0]             sel_idx;
  logic [P_CONSUMER_NUM-1:0] sel_onehot;
  logic                      drain;
  logic                      accept;

  // Lowest eligible index in three candidate places: current round above the
  // pointer, the next round, and round 0. Descending scan leaves the lowest hit.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    hit_c = 1'b0;
    idx_a = '0;
    idx_b = '0;
    idx_c = '0;
    for (int i = int'(P_CONSUMER_NUM) - 1; i >= 0; i--) begin
      if (cons_en_i[i] && weight(i) > 32'(round_q) && i > int'(ptr_q)) begin
        hit_a = 1'b1;
        idx_a = PW'(i);
      end
      if (cons_en_i[i] && weight(i) > 32'(round_q) + 32'd1) begin
        hit_b = 1'b1;
        idx_b = PW'(i);
      end
      if (cons_en_i[i]) begin
        hit_c = 1'b1;
        idx_c = PW'(i);
      end
    end
  end

  always_comb begin
    last_round = (32'(round_q) == W0 - 1);
    if (hit_a) begin
      sel_round = round_q;
      sel_idx   = idx_a;
    end else if (!last_round && hit_b) begin
      sel_round = round_q + RW'(1);
      sel_idx   = idx_b;
    end else begin
      sel_round = '0;
      sel_idx   = idx_c;
    end
    for (int i = 0; i < int'(P_CONSUMER_NUM); i++) begin
      sel_onehot[i] = (PW'(i) == sel_idx);
    end
  end

  assign drain       = |(tgt_q & dst_ready_i);
  // Gated by rst_n so the source sees no ready while reset is held.
  assign src_ready_o = rst_n & (|cons_en_i) & (~(|tgt_q) | drain);
  assign accept      = src_valid_i & src_ready_o & hit_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_q <= RW'(W0 - 1);
      ptr_q   <= PW'(P_CONSUMER_NUM - 1);
      tgt_q   <= '0;
      data_q  <= '0;
    end else if (accept) begin
      round_q <= sel_round;
      ptr_q   <= sel_idx;
      tgt_q   <= sel_onehot;
      data_q  <= src_data_i;
    end else if (drain) begin
      tgt_q   <= '0;
    end
  end

  assign dst_valid_o = tgt_q;
  assign dst_data_o  = data_q;

endmodule

// File: tb/tb_dispatcher_iwrr.sv
module tb_dispatcher_iwrr;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int W0 = 5;
  int wt [N] = '{5, 3, 2};

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_ready;
  logic [N-1:0]  cons_en = '0;
  logic [N-1:0]  dst_valid;
  logic [DW-1:0] dst_data;
  logic [N-1:0]  dst_ready = '0;

  dispatcher_iwrr #(
    .P_CONSUMER_NUM   (N),
    .P_CONSUMER_WEIGHT({32'd5, 32'd3, 32'd2}),
    .P_DATA_W         (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid_i(src_valid),
    .src_data_i (src_data),
    .src_ready_o(src_ready),
    .cons_en_i  (cons_en),
    .dst_valid_o(dst_valid),
    .dst_data_o (dst_data),
    .dst_ready_i(dst_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tgt;
    logic [31:0] data;
  } item_t;

  item_t exp_q[$];
  int    vectors = 0;
  int    errors  = 0;
  int    mr = W0 - 1;
  int    mp = N - 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference schedule: all (round, index) slots in lexicographic order; the
  // next target is the first slot after (r, p), wrapping to the first slot.
  task automatic model_next(input logic [N-1:0] en, input int r, input int p,
                            output int nr, output int np);
    bit found = 0;
    bit have_first = 0;
    int fr = 0, fp = 0;
    nr = 0;
    np = 0;
    for (int rr = 0; rr < W0; rr++) begin
      for (int i = 0; i < N; i++) begin
        if (en[i] && wt[i] > rr) begin
          if (!have_first) begin
            have_first = 1;
            fr = rr;
            fp = i;
          end
          if (!found && (rr > r || (rr == r && i > p))) begin
            found = 1;
            nr = rr;
            np = i;
          end
        end
      end
    end
    if (!found) begin
      nr = fr;
      np = fp;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mr = W0 - 1;
    mp = N - 1;
  endtask

  // Monitor: compares presented outputs with the scoreboard head, pops on transfer.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        logic [N-1:0] ev;
        logic         er;
        ev = '0;
        if (exp_q.size() > 0) ev[exp_q[0].tgt] = 1'b1;
        check("dst_valid", 32'(dst_valid), 32'(ev));
        if (exp_q.size() > 0) check("dst_data", dst_data, exp_q[0].data);
        er = (|cons_en) && (exp_q.size() == 0 || dst_ready[exp_q[0].tgt]);
        check("src_ready", 32'(src_ready), 32'(er));
        if (exp_q.size() > 0 && dst_ready[exp_q[0].tgt]) void'(exp_q.pop_front());
      end
    end
  end

  // Source side: on acceptance, predict the target and push the expected item.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && src_valid && src_ready) begin
        int nr, np;
        item_t it;
        model_next(cons_en, mr, mp, nr, np);
        mr = nr;
        mp = np;
        it.tgt  = np;
        it.data = src_data;
        exp_q.push_back(it);
      end
    end
  end

  task automatic drive(input int cycles, input logic [N-1:0] en, input logic [N-1:0] rdy,
                       input logic vld);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      cons_en   = en;
      dst_ready = rdy;
      src_valid = vld;
      src_data  = $urandom;
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    src_valid = 1'b1;
    cons_en   = 3'b111;
    dst_ready = 3'b111;
    #2;
    check("reset_dst_valid", 32'(dst_valid), 32'h0);
    check("reset_src_ready", 32'(src_ready), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full enable, continuous traffic: 0,1,2,0,1,2,0,1,0,0 pattern.
    drive(25, 3'b111, 3'b111, 1'b1);
    drive(16, 3'b011, 3'b111, 1'b1);
    drive(8, 3'b001, 3'b111, 1'b1);
    drive(6, 3'b000, 3'b111, 1'b1);

    // Back-pressure on consumer 1 for five cycles.
    drive(1, 3'b111, 3'b111, 1'b1);
    drive(5, 3'b111, 3'b101, 1'b1);
    drive(6, 3'b111, 3'b111, 1'b1);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] en;
      en = (k % 20 < 15) ? 3'b111 : N'($urandom_range(0, 7));
      drive(1, en, N'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset between edges with an item buffered.
    drive(3, 3'b111, 3'b000, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midreset_dst_valid", 32'(dst_valid), 32'h0);
    check("midreset_src_ready", 32'(src_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(8, 3'b110, 3'b111, 1'b1);

    // Enable change while an item is held for consumer 0.
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 3'b111, 3'b000, 1'b1);
    drive(3, 3'b100, 3'b000, 1'b1);
    drive(8, 3'b100, 3'b111, 1'b1);
    drive(4, 3'b111, 3'b111, 1'b0);

    @(negedge clk);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dispatcher_iwrr.md
DISPATCHER_IWRR -- requirements
Module: dispatcher_iwrr

Interface
REQ-001 P_CONSUMER_NUM, default 3, number of output consumers (>=2).
REQ-002 P_CONSUMER_WEIGHT, default {32'd5,32'd3,32'd2}, packed [0:P_CONSUMER_NUM*32-1], 32-bit weight per consumer, index 0 holds the maximum weight, every weight >=1.
REQ-003 P_DATA_W, default 32, payload width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 src_valid_i  input  1  source item valid.
REQ-007 src_data_i  input  P_DATA_W  source payload.
REQ-008 src_ready_o  output  1  source item accepted when src_valid_i & src_ready_o at a rising edge.
REQ-009 cons_en_i  input  P_CONSUMER_NUM  per-consumer enable mask; disabled consumers are skipped by the schedule.
REQ-010 dst_valid_o  output  P_CONSUMER_NUM  one-hot (or zero) valid toward consumers.
REQ-011 dst_data_o  output  P_DATA_W  payload broadcast to all consumers, meaningful only where dst_valid_o is set.
REQ-012 dst_ready_i  input  P_CONSUMER_NUM  per-consumer ready; transfer to consumer i when dst_valid_o[i] & dst_ready_i[i].

Function
REQ-013 Block SHALL be the 1-to-N counterpart of the IWRR arbiter: one source stream dispatched to N consumers in interleaved weighted round-robin order.
REQ-014 Schedule state SHALL be round counter R (width max(1,clog2(weight[0])), range 0..weight[0]-1) and last-index pointer P (width max(1,clog2(P_CONSUMER_NUM))).
REQ-015 Consumer i SHALL be eligible in round R iff cons_en_i[i]=1 and weight[i]>R.
REQ-016 Next target SHALL be the lowest eligible index >P in round R; if none, the lowest eligible index in round R+1; if none there (or R=weight[0]-1), the lowest eligible index in round 0 with R wrapping to 0.
REQ-017 On acceptance, R and P SHALL update to the round and index of the selected target; no update without acceptance.
REQ-018 One output buffer (payload + one-hot target) SHALL exist; src_ready_o = (|cons_en_i) & (buffer empty | target consumer's dst_ready_i).
REQ-019 Accepted item SHALL appear on dst_valid_o/dst_data_o the cycle after acceptance (latency 1); back-to-back acceptance at full throughput when targets are ready.
REQ-020 Buffered item SHALL hold target and payload stable until transferred, regardless of later cons_en_i changes.
REQ-021 With cons_en_i=0, src_ready_o SHALL be 0 and R/P SHALL hold; a buffered item still drains.
REQ-022 Simultaneous transfer-out and accept SHALL replace buffer contents in the same edge with no bubble.
REQ-023 dst_valid_o SHALL never have more than one bit set.

Reset
REQ-024 During rst_n=0 (asynchronously): dst_valid_o=0, buffer empty, R=weight[0]-1, P=P_CONSUMER_NUM-1, so the first target after reset is the lowest enabled index in round 0.
REQ-025 src_ready_o SHALL be 0 while rst_n=0; reset mid-transfer discards the buffered item.
REQ-026 dst_data_o value during reset is don't-care; reset SHALL be usable with no clock running.

Verification
REQ-027 Weights {5,3,2}, cons_en_i=3'b111, dst_ready_i=3'b111, src_valid_i=1 continuously -> dst_valid_o target sequence 0,1,2,0,1,2,0,1,0,0 repeating, one item per cycle, payload order preserved.
REQ-028 cons_en_i=3'b011, all ready, continuous source -> sequence 0,1,0,1,0,1,0,0 repeating; consumer 2 never valid.
REQ-029 cons_en_i=3'b001 -> every item to consumer 0 (dst_valid_o=3'b001 each cycle); cons_en_i=3'b000 -> src_ready_o=0, no new dst_valid_o after buffer drains.
REQ-030 Target consumer 1 holds dst_ready_i[1]=0 for 5 cycles -> dst_valid_o=3'b010 and dst_data_o stable for 5 cycles, src_ready_o=0, then transfer and schedule resumes at consumer 2.
REQ-031 Assert rst_n=0 between clock edges with item buffered -> dst_valid_o=0 immediately; after release the first item goes to the lowest enabled consumer.
REQ-032 Change cons_en_i from 3'b111 to 3'b100 while item buffered for consumer 0 -> item still delivered to consumer 0; subsequent items to consumer 2 only.
